// File: rtl/ccc_rst_pkg.sv
// Shared types and constants for the CCC lock / reset sequencer.
package ccc_rst_pkg;

  localparam int LOST_CNT_W = 8;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    REL_FAB   = 3'd1,
    RUN       = 3'd2,
    SOFT      = 3'd3
  } seq_state_t;

endpackage

// File: rtl/sync_ff_n.sv
// N-stage single-bit synchronizer with asynchronous active-low reset to 0.
module sync_ff_n #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments and an async
  // active-low reset so every flop clears without needing a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/ccc_lock_reset_seq.sv
// Qualifies CCC lock, sequences fabric then NAND-controller reset release,
// filters lock loss and handles NAND-controller soft resets.
module ccc_lock_reset_seq
  import ccc_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int LOSS_FILT_CYC   = 4,
  parameter int CORE_DLY_CYC    = 16,
  parameter int SOFT_RST_CYC    = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  PLL_LOCK,
  input  logic                  SOFT_RST_REQ,
  output logic                  FAB_RESET_N,
  output logic                  NFC_RESET_N,
  output logic                  LOCK_OK,
  output logic [LOST_CNT_W-1:0] LOCK_LOST_CNT,
  output logic [2:0]            SEQ_STATE
);

  localparam int STAB_W = $clog2(LOCK_STABLE_CYC + 1);
  localparam int LOSS_W = $clog2(LOSS_FILT_CYC + 1);
  localparam int DLY_W  = $clog2(CORE_DLY_CYC + 1);
  localparam int SOFT_W = $clog2(SOFT_RST_CYC + 1);

  logic lock_s;

  sync_ff_n #(.N(SYNC_STAGES)) u_lock_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d_i   (PLL_LOCK),
    .q_o   (lock_s)
  );

  seq_state_t            state_q, state_d;
  logic [STAB_W-1:0]     stab_cnt_q, stab_cnt_d;
  logic [LOSS_W-1:0]     loss_cnt_q, loss_cnt_d;
  logic [DLY_W-1:0]      dly_cnt_q,  dly_cnt_d;
  logic [SOFT_W-1:0]     soft_cnt_q, soft_cnt_d;
  logic [LOST_CNT_W-1:0] lost_cnt_q, lost_cnt_d;
  logic                  fab_q, fab_d, nfc_q, nfc_d, lock_ok_q, lock_ok_d;

  logic stab_done, dly_done, soft_done, loss_hit;

  assign stab_done = lock_s && (stab_cnt_q == STAB_W'(LOCK_STABLE_CYC - 1));
  assign dly_done  = (dly_cnt_q  == DLY_W'(CORE_DLY_CYC - 1));
  assign soft_done = (soft_cnt_q == SOFT_W'(SOFT_RST_CYC - 1));
  // The LOSS_FILT_CYC-th consecutive low sample is the qualified loss.
  assign loss_hit  = (state_q != WAIT_LOCK) && !lock_s &&
                     (loss_cnt_q == LOSS_W'(LOSS_FILT_CYC - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= WAIT_LOCK;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: if (stab_done) state_d = REL_FAB;
      REL_FAB:   if (loss_hit) state_d = WAIT_LOCK;
                 else if (dly_done) state_d = RUN;
      RUN:       if (loss_hit) state_d = WAIT_LOCK;
                 else if (SOFT_RST_REQ) state_d = SOFT;
      SOFT:      if (loss_hit) state_d = WAIT_LOCK;
                 else if (soft_done) state_d = RUN;
      default:   state_d = WAIT_LOCK;
    endcase
  end

  always_comb begin
    stab_cnt_d = '0;
    if (state_q == WAIT_LOCK && lock_s)
      stab_cnt_d = stab_done ? stab_cnt_q : stab_cnt_q + STAB_W'(1);

    loss_cnt_d = '0;
    if (state_q != WAIT_LOCK && !lock_s && !loss_hit)
      loss_cnt_d = loss_cnt_q + LOSS_W'(1);

    dly_cnt_d  = (state_q == REL_FAB && state_d == REL_FAB) ? dly_cnt_q + DLY_W'(1)  : '0;
    soft_cnt_d = (state_q == SOFT    && state_d == SOFT)    ? soft_cnt_q + SOFT_W'(1) : '0;

    lost_cnt_d = lost_cnt_q;
    if (loss_hit && lost_cnt_q != '1) lost_cnt_d = lost_cnt_q + LOST_CNT_W'(1);

    // Output flops load the value implied by the state being entered.
    fab_d     = (state_d != WAIT_LOCK);
    lock_ok_d = (state_d != WAIT_LOCK);
    nfc_d     = (state_d == RUN);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stab_cnt_q <= '0;
      loss_cnt_q <= '0;
      dly_cnt_q  <= '0;
      soft_cnt_q <= '0;
      lost_cnt_q <= '0;
      fab_q      <= 1'b0;
      nfc_q      <= 1'b0;
      lock_ok_q  <= 1'b0;
    end else begin
      stab_cnt_q <= stab_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      dly_cnt_q  <= dly_cnt_d;
      soft_cnt_q <= soft_cnt_d;
      lost_cnt_q <= lost_cnt_d;
      fab_q      <= fab_d;
      nfc_q      <= nfc_d;
      lock_ok_q  <= lock_ok_d;
    end
  end

  assign FAB_RESET_N   = fab_q;
  assign NFC_RESET_N   = nfc_q;
  assign LOCK_OK       = lock_ok_q;
  assign LOCK_LOST_CNT = lost_cnt_q;
  assign SEQ_STATE     = state_q;

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Directed bench for ccc_lock_reset_seq with small parameters and hand-computed timing.
module tb_ccc_lock_reset_seq;

  logic       clk;
  logic       reset_n;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       fab_reset_n;
  logic       nfc_reset_n;
  logic       lock_ok;
  logic [7:0] lock_lost_cnt;
  logic [2:0] seq_state;

  int n_vec = 0;
  int n_err = 0;

  ccc_lock_reset_seq #(
    .SYNC_STAGES     (2),
    .LOCK_STABLE_CYC (8),
    .LOSS_FILT_CYC   (3),
    .CORE_DLY_CYC    (4),
    .SOFT_RST_CYC    (5)
  ) dut (
    .CLK           (clk),
    .RESET_N       (reset_n),
    .PLL_LOCK      (pll_lock),
    .SOFT_RST_REQ  (soft_rst_req),
    .FAB_RESET_N   (fab_reset_n),
    .NFC_RESET_N   (nfc_reset_n),
    .LOCK_OK       (lock_ok),
    .LOCK_LOST_CNT (lock_lost_cnt),
    .SEQ_STATE     (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic fab, input logic nfc,
                         input logic lok, input logic [2:0] st, input logic [7:0] cnt);
    check({tag, "/fab"},   32'(fab_reset_n),   32'(fab));
    check({tag, "/nfc"},   32'(nfc_reset_n),   32'(nfc));
    check({tag, "/lok"},   32'(lock_ok),       32'(lok));
    check({tag, "/state"}, 32'(seq_state),     32'(st));
    check({tag, "/cnt"},   32'(lock_lost_cnt), 32'(cnt));
  endtask

  initial begin
    reset_n      = 1'b0;
    pll_lock     = 1'b1;
    soft_rst_req = 1'b0;

    // Reset state, then power-up sequence; edge 0 is the first edge after release.
    tick(3);
    exp_out("reset", 0, 0, 0, 3'd0, 8'd0);
    reset_n = 1'b1;
    tick(9);
    exp_out("pwr_e8", 0, 0, 0, 3'd0, 8'd0);
    tick(1);
    exp_out("pwr_e9", 1, 0, 1, 3'd1, 8'd0);
    tick(3);
    exp_out("pwr_e12", 1, 0, 1, 3'd1, 8'd0);
    tick(1);
    exp_out("pwr_e13", 1, 1, 1, 3'd2, 8'd0);

    // Two-cycle lock glitch in RUN: filtered out.
    pll_lock = 1'b0;
    tick(2);
    pll_lock = 1'b1;
    tick(6);
    exp_out("glitch2", 1, 1, 1, 3'd2, 8'd0);

    // Three-cycle low: qualified loss, then full re-sequence.
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    tick(1);
    exp_out("loss3_pre", 1, 1, 1, 3'd2, 8'd0);
    tick(1);
    exp_out("loss3", 0, 0, 0, 3'd0, 8'd1);
    tick(7);
    exp_out("relock_e12", 0, 0, 0, 3'd0, 8'd1);
    tick(1);
    exp_out("relock_e13", 1, 0, 1, 3'd1, 8'd1);
    tick(4);
    exp_out("relock_e17", 1, 1, 1, 3'd2, 8'd1);

    // Soft reset: exactly 5 cycles low, a second request during SOFT ignored.
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    exp_out("soft_e0", 1, 0, 1, 3'd3, 8'd1);
    tick(1);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(2);
    exp_out("soft_e4", 1, 0, 1, 3'd3, 8'd1);
    tick(1);
    exp_out("soft_e5", 1, 1, 1, 3'd2, 8'd1);
    tick(3);
    exp_out("soft_noreq", 1, 1, 1, 3'd2, 8'd1);

    // Loss into WAIT_LOCK; soft request there has no effect.
    pll_lock = 1'b0;
    tick(5);
    exp_out("loss_b", 0, 0, 0, 3'd0, 8'd2);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(1);
    exp_out("soft_in_wait", 0, 0, 0, 3'd0, 8'd2);

    // Qualification restart: high 6, low 1, high again.
    pll_lock = 1'b1;
    tick(6);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(5);
    exp_out("restart_y12", 0, 0, 0, 3'd0, 8'd2);
    tick(4);
    exp_out("restart_y16", 0, 0, 0, 3'd0, 8'd2);
    tick(1);
    exp_out("restart_y17", 1, 0, 1, 3'd1, 8'd2);
    tick(4);
    exp_out("restart_y21", 1, 1, 1, 3'd2, 8'd2);

    // Qualified loss coincides with soft request: loss wins.
    pll_lock = 1'b0;
    tick(4);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    exp_out("loss_vs_soft", 0, 0, 0, 3'd0, 8'd3);

    // Async reset in the middle of REL_FAB.
    pll_lock = 1'b1;
    tick(10);
    exp_out("pre_rst_relfab", 1, 0, 1, 3'd1, 8'd3);
    tick(1);
    #2;
    reset_n = 1'b0;
    #1;
    exp_out("async_rst", 0, 0, 0, 3'd0, 8'd0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    exp_out("post_rst_e9", 1, 0, 1, 3'd1, 8'd0);

    // 260 qualified losses: counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      pll_lock = 1'b0;
      tick(5);
      if (i == 0)   check("sat_first", 32'(lock_lost_cnt), 32'd1);
      if (i == 253) check("sat_254",   32'(lock_lost_cnt), 32'd254);
      if (i == 254) check("sat_255",   32'(lock_lost_cnt), 32'd255);
      pll_lock = 1'b1;
      tick(10);
    end
    exp_out("sat_final", 1, 0, 1, 3'd1, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
